mul_qb_add_r: RTL and testbench

Sequential shift-add multiply-accumulate unit computing P = Q·B + R, the inverse operation of the team's sequential restoring divider. It shares that divider's operand widths: Q is quotient-sized and B/R are divisor-sized. It reconstructs the dividend from a division result for self-check, and serves as a general narrow-area multiplier. It processes one multiplier bit per clock, LSB-first, using the same `st`/`ok_` start-and-done pulse style as the divider.

---
 rtl/mul_qb_add_r_if.sv | 49 ++++
 rtl/mul_qb_add_r.sv | 119 +++++++++++
 tb/tb_mul_qb_add_r.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_qb_add_r_if.sv
// -----------------------------------------------------------------------------
// mul_qb_add_r_if
//   Bundles the start/operand/result signals of the sequential multiply-add
//   unit mul_qb_add_r.
//
//   Parameters
//     M_Q : multiplicand width (quotient-sized)
//     M_B : multiplier / addend width (divisor-sized)
//
//   Signals
//     st      start pulse, operands sampled on the edge where st=1
//     Q       multiplicand
//     B       multiplier
//     R       addend, preloads the accumulator
//     P       result register, M_Q+M_B bits
//     ok_mul  one-cycle done pulse, P valid in the same cycle
//     busy    high while an operation is in progress
//
//   Handshake: there is no back-pressure. The master may raise st in any
//   cycle, including a busy cycle (abort and restart) and the ok_mul cycle.
//   The slave always accepts st and answers with exactly one ok_mul per
//   operation that is not aborted.
//
//   Modports
//     master : drives st/Q/B/R, observes P/ok_mul/busy
//     slave  : the multiply-add unit
// -----------------------------------------------------------------------------
interface mul_qb_add_r_if #(
    parameter int M_Q = 27,
    parameter int M_B = 16
);
    logic                 st;
    logic [M_Q-1:0]       Q;
    logic [M_B-1:0]       B;
    logic [M_B-1:0]       R;
    logic [M_Q+M_B-1:0]   P;
    logic                 ok_mul;
    logic                 busy;

    modport master (
        output st, Q, B, R,
        input  P, ok_mul, busy
    );

    modport slave (
        input  st, Q, B, R,
        output P, ok_mul, busy
    );
endinterface

// File: rtl/mul_qb_add_r.sv
// -----------------------------------------------------------------------------
// mul_qb_add_r
//   Sequential shift-add multiply-accumulate: P = Q*B + R.
//   One multiplier bit is consumed per clock, LSB first. The accumulator is
//   preloaded with R, so the result reconstructs a dividend from the
//   quotient/remainder of the matching restoring divider.
//
//   Parameters
//     M_Q : multiplicand width (default 27)
//     M_B : multiplier / addend width (default 16)
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of mul_qb_add_r_if (st, Q, B, R, P, ok_mul, busy)
//
//   Build option
//     MUL_EARLY_EXIT_EN : when defined, the operation also finishes as soon as
//     the remaining (post-shift) multiplier is zero. Results are identical;
//     only latency shrinks. Undefined: latency is always M_B cycles.
//
//   Timing: st sampled at edge k, steps at edges k+1..k+M_B (or fewer with
//   early exit), ok_mul and the new P appear after the final step edge.
//   The FSM state is visible directly on bus.busy (RUN <=> busy).
// -----------------------------------------------------------------------------
module mul_qb_add_r #(
    parameter int M_Q = 27,
    parameter int M_B = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_qb_add_r_if.slave  bus
);
    localparam int W = M_Q + M_B;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bf_q_q,  bf_q_d;    // shifted multiplicand
    logic [M_B-1:0]  bf_b_q,  bf_b_d;    // shifted multiplier
    logic [W-1:0]    acc_q,   acc_d;
    logic [7:0]      cb_tact_q, cb_tact_d;
    logic [W-1:0]    p_q,     p_d;
    logic            ok_q,    ok_d;

    logic [W-1:0]    sum;
    logic            last_step;

    // Accumulate this step's partial product. The worst-case result
    // (2^M_Q-1)(2^M_B-1)+(2^M_B-1) fits in W bits, so no carry-out exists.
    always_comb begin
        sum = bf_b_q[0] ? (acc_q + bf_q_q) : acc_q;
    end

    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        last_step = (cb_tact_q == 8'(M_B - 1)) || ((bf_b_q >> 1) == '0);
`else
        last_step = (cb_tact_q == 8'(M_B - 1));
`endif
    end

    always_comb begin
        state_d   = state_q;
        bf_q_d    = bf_q_q;
        bf_b_d    = bf_b_q;
        acc_d     = acc_q;
        cb_tact_d = cb_tact_q;
        p_d       = p_q;
        ok_d      = 1'b0;

        if (bus.st) begin
            // Start wins over a running operation: abort and reload.
            state_d   = RUN;
            bf_q_d    = {{M_B{1'b0}}, bus.Q};
            bf_b_d    = bus.B;
            acc_d     = {{M_Q{1'b0}}, bus.R};
            cb_tact_d = 8'd0;
        end else if (state_q == RUN) begin
            acc_d     = sum;
            bf_q_d    = bf_q_q << 1;
            bf_b_d    = bf_b_q >> 1;
            cb_tact_d = cb_tact_q + 8'd1;
            if (last_step) begin
                state_d = IDLE;
                p_d     = sum;
                ok_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bf_q_q    <= '0;
            bf_b_q    <= '0;
            acc_q     <= '0;
            cb_tact_q <= '0;
            p_q       <= '0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bf_q_q    <= bf_q_d;
            bf_b_q    <= bf_b_d;
            acc_q     <= acc_d;
            cb_tact_q <= cb_tact_d;
            p_q       <= p_d;
            ok_q      <= ok_d;
        end
    end

    assign bus.P      = p_q;
    assign bus.ok_mul = ok_q;
    assign bus.busy   = (state_q == RUN);

endmodule

// File: tb/tb_mul_qb_add_r.sv
// -----------------------------------------------------------------------------
// tb_mul_qb_add_r
//   Directed-vector bench for mul_qb_add_r with hand-computed results.
// -----------------------------------------------------------------------------
module tb_mul_qb_add_r;
    localparam int M_Q = 27;
    localparam int M_B = 16;
    localparam int W   = M_Q + M_B;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_qb_add_r_if #(.M_Q(M_Q), .M_B(M_B)) bus ();

    mul_qb_add_r #(.M_Q(M_Q), .M_B(M_B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_p = '0;   // result the bench expects P to be holding

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected latency for multiplier b in the current build.
    function automatic int exp_lat(input logic [M_B-1:0] b);
        int l;
        l = 1;
        for (int i = 0; i < M_B; i++) if (b[i]) l = i + 1;
`ifdef MUL_EARLY_EXIT_EN
        return l;
`else
        return (l > 0) ? M_B : M_B;
`endif
    endfunction

    // ---------------- driver ----------------
    // Entered and left at a negedge. st is held for 'hold' edges; latency is
    // counted from the last st edge. Leaves the bench in the ok_mul cycle.
    task automatic run_op(input string tag, input logic [M_Q-1:0] q, input logic [M_B-1:0] b,
                          input logic [M_B-1:0] r, input logic [W-1:0] exp_p, input int hold);
        int   n;
        bit   got;
        bit   held_ok;
        logic [W-1:0] e;
        bus.st = 1'b1; bus.Q = q; bus.B = b; bus.R = r;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.st = 1'b0;
        exp_q.push_back(exp_p);
        check({tag, "_busy_hi"}, 64'(bus.busy), 64'd1);
        n = 0; got = 0; held_ok = 1;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.ok_mul) got = 1;
            else if (bus.P !== last_p) held_ok = 0;
        end
        if (!got) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lat"}, 64'(n), 64'(exp_lat(b)));
            check({tag, "_P"}, 64'(bus.P), 64'(e));
            check({tag, "_busy_lo"}, 64'(bus.busy), 64'd0);
            last_p = e;
        end
        check({tag, "_P_held"}, 64'(held_ok), 64'd1);
    endtask

    task automatic ok_low_next(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ok_drop"}, 64'(bus.ok_mul), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw_ok;
        bus.st = 1'b0; bus.Q = '0; bus.B = '0; bus.R = '0;
        #3;
        check("rst_P",    64'(bus.P),      64'd0);
        check("rst_busy", 64'(bus.busy),   64'd0);
        check("rst_ok",   64'(bus.ok_mul), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 27'd5, 16'd3, 16'd2, 43'd17, 1);
        ok_low_next("basic");

        run_op("max", 27'h7FF_FFFF, 16'hFFFF, 16'hFFFF, 43'h7FF_F800_0000, 1);
        ok_low_next("max");

        run_op("b_zero", 27'd123, 16'd0, 16'd7, 43'd7, 1);
        ok_low_next("b_zero");

        run_op("b_bit4", 27'd9, 16'h0010, 16'd0, 43'd144, 1);
        ok_low_next("b_bit4");

        // Restart: first op aborted by a second st four edges later.
        bus.st = 1'b1; bus.Q = 27'd5; bus.B = 16'd3; bus.R = 16'd0;
        @(posedge clk);
        @(negedge clk);
        bus.st = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("restart_no_early_ok", 64'(bus.ok_mul), 64'd0);
        run_op("restart", 27'd7, 16'd6, 16'd1, 43'd43, 1);

        // New st issued in the ok_mul cycle of the previous operation.
        run_op("b2b", 27'd2, 16'd3, 16'd4, 43'd10, 1);
        ok_low_next("b2b");

        // st held for three edges; only the last load counts.
        run_op("hold", 27'd3, 16'd4, 16'd0, 43'd12, 3);
        ok_low_next("hold");

        // Asynchronous reset in the middle of an operation.
        bus.st = 1'b1; bus.Q = 27'd5; bus.B = 16'd3; bus.R = 16'd2;
        @(posedge clk);
        @(negedge clk);
        bus.st = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_P",    64'(bus.P),      64'd0);
        check("midrst_busy", 64'(bus.busy),   64'd0);
        check("midrst_ok",   64'(bus.ok_mul), 64'd0);
        last_p = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw_ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ok_mul) saw_ok = 1;
        end
        check("midrst_no_ok", 64'(saw_ok), 64'd0);
        run_op("after_rst", 27'd10, 16'd10, 16'd5, 43'd105, 1);
        ok_low_next("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
